// File: rtl/smvm_group_scheduler.sv
// smvm_group_scheduler: packs streamed sparse-matrix elements into K-lane groups and issues them
// to the multiplier pipeline under credit flow control, pulsing done once every group has retired.
module smvm_group_scheduler #(
    parameter int K            = 4,
    parameter int VAL_W        = 8,
    parameter int COL_W        = 7,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               elem_valid,
    output logic               elem_ready,
    input  logic [VAL_W-1:0]   elem_val,
    input  logic [COL_W-1:0]   elem_col,
    input  logic               elem_ipv,
    input  logic               elem_last,
    output logic               grp_valid,
    input  logic               grp_ready,
    output logic [K*VAL_W-1:0] grp_val,
    output logic [K*COL_W-1:0] grp_col,
    output logic [K-1:0]       grp_ipv,
    output logic [2:0]         grp_cnt,
    output logic               grp_last,
    input  logic               ret_valid,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   issued_cnt,
    output logic               err
);
    localparam int SLOT_W = $clog2(K);
    localparam int CR_W   = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CR_W-1:0] CR_MAX = CR_W'(MAX_INFLIGHT);

    typedef enum logic [2:0] {IDLE, FILL, ISSUE, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [SLOT_W-1:0] slot;
    logic [CR_W-1:0]   credits;
    logic              elem_hs, grp_hs, ret_ok;

    assign elem_hs = elem_valid && elem_ready;
    assign grp_hs  = grp_valid && grp_ready;
    assign ret_ok  = ret_valid && credits != CR_MAX;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? FILL : IDLE;
            FILL:    state_nxt = (elem_hs && (slot == SLOT_W'(K - 1) || elem_last)) ? ISSUE : FILL;
            ISSUE:   state_nxt = grp_hs ? (grp_last ? DRAIN : FILL) : ISSUE;
            DRAIN:   state_nxt = (credits == CR_MAX) ? DONE : DRAIN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        elem_ready = state == FILL;
        grp_valid  = state == ISSUE && credits != '0;
        busy       = state != IDLE;
        done       = state == DONE;
    end

    // Payload is cleared on issue so unfilled lanes of the next group read as zero padding.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot       <= '0;
            credits    <= CR_MAX;
            grp_val    <= '0;
            grp_col    <= '0;
            grp_ipv    <= '0;
            grp_cnt    <= '0;
            grp_last   <= 1'b0;
            issued_cnt <= '0;
            err        <= 1'b0;
        end else begin
            credits <= credits + CR_W'(ret_ok) - CR_W'(grp_hs);
            if (ret_valid && !ret_ok)
                err <= 1'b1;
            if (state == IDLE && start) begin
                slot       <= '0;
                issued_cnt <= '0;
                err        <= 1'b0;
            end
            if (elem_hs) begin
                grp_val[VAL_W*(K-1-int'(slot)) +: VAL_W] <= elem_val;
                grp_col[COL_W*(K-1-int'(slot)) +: COL_W] <= elem_col;
                grp_ipv[K-1-int'(slot)]                  <= elem_ipv;
                grp_cnt                                  <= 3'(int'(slot) + 1);
                grp_last                                 <= elem_last;
                slot                                     <= slot + SLOT_W'(1);
            end
            if (grp_hs) begin
                slot     <= '0;
                grp_val  <= '0;
                grp_col  <= '0;
                grp_ipv  <= '0;
                grp_cnt  <= '0;
                grp_last <= 1'b0;
                if (issued_cnt != '1)
                    issued_cnt <= issued_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_smvm_group_scheduler.sv
// tb_smvm_group_scheduler: table-driven passes, hand-built corner sequences and random passes,
// all checked cycle by cycle against a transaction-level model of grouping and credits.
module tb_smvm_group_scheduler;
    localparam int K = 4, VAL_W = 8, COL_W = 7, MAXI = 4, CNT_W = 16;

    typedef struct {
        logic [VAL_W-1:0] v;
        logic [COL_W-1:0] c;
        logic             i;
        logic             l;
    } elem_t;

    typedef struct {
        int               n;
        int               groups;
        int               lcnt;
        logic [K*VAL_W-1:0] lv;
        logic [K*COL_W-1:0] lc;
        logic [K-1:0]       li;
    } vec_t;

    logic clk = 0, rst = 1, start = 0, elem_valid = 0, elem_ipv = 0, elem_last = 0;
    logic grp_ready = 0, ret_valid = 0;
    logic [VAL_W-1:0] elem_val = 0;
    logic [COL_W-1:0] elem_col = 0;
    logic elem_ready, grp_valid, grp_last, busy, done, err;
    logic [K*VAL_W-1:0] grp_val;
    logic [K*COL_W-1:0] grp_col;
    logic [K-1:0]       grp_ipv;
    logic [2:0]         grp_cnt;
    logic [CNT_W-1:0]   issued_cnt;

    smvm_group_scheduler #(.K(K), .VAL_W(VAL_W), .COL_W(COL_W), .MAX_INFLIGHT(MAXI), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .elem_valid(elem_valid), .elem_ready(elem_ready),
        .elem_val(elem_val), .elem_col(elem_col), .elem_ipv(elem_ipv), .elem_last(elem_last),
        .grp_valid(grp_valid), .grp_ready(grp_ready), .grp_val(grp_val), .grp_col(grp_col),
        .grp_ipv(grp_ipv), .grp_cnt(grp_cnt), .grp_last(grp_last), .ret_valid(ret_valid),
        .busy(busy), .done(done), .issued_cnt(issued_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit m_fill, m_pend, m_drain, m_done, m_err;
    int m_o, m_iss;
    elem_t cur[$];
    logic [K*VAL_W-1:0] e_val, seen_val;
    logic [K*COL_W-1:0] e_col, seen_col;
    logic [K-1:0]       e_ipv, seen_ipv;
    int e_cnt;
    bit e_last;
    logic [2:0] seen_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_fill = 0; m_pend = 0; m_drain = 0; m_done = 0; m_err = 0;
        m_o = 0; m_iss = 0;
        cur.delete();
    endfunction

    // One clock: compare DUT against the model, advance the model, then clock.
    task automatic step(input bit s, input bit ev, input bit gr, input bit rv, input elem_t e);
        bit busy_m, hs_e, hs_g, dn;
        rst = 0; start = s; elem_valid = ev; elem_val = e.v; elem_col = e.c; elem_ipv = e.i;
        elem_last = e.l; grp_ready = gr; ret_valid = rv;
        busy_m = m_fill || m_pend || m_drain || m_done;
        chk("elem_ready", 64'(elem_ready), 64'(m_fill));
        chk("grp_valid", 64'(grp_valid), 64'(m_pend && m_o < MAXI));
        chk("busy", 64'(busy), 64'(busy_m));
        chk("done", 64'(done), 64'(m_done));
        chk("err", 64'(err), 64'(m_err));
        chk("issued_cnt", 64'(issued_cnt), 64'(m_iss));
        if (m_pend) begin
            chk("grp_val", 64'(grp_val), 64'(e_val));
            chk("grp_col", 64'(grp_col), 64'(e_col));
            chk("grp_ipv", 64'(grp_ipv), 64'(e_ipv));
            chk("grp_cnt", 64'(grp_cnt), 64'(e_cnt));
            chk("grp_last", 64'(grp_last), 64'(e_last));
        end
        hs_e = ev && m_fill;
        hs_g = m_pend && m_o < MAXI && gr;
        dn = m_drain && m_o == 0;
        if (rv) begin
            if (m_o == 0) m_err = 1;
            else m_o--;
        end
        if (!busy_m && s) begin
            m_fill = 1; m_err = 0; m_iss = 0; cur.delete();
        end
        if (hs_g) begin
            seen_val = grp_val; seen_col = grp_col; seen_ipv = grp_ipv; seen_cnt = grp_cnt;
            m_o++; m_pend = 0;
            if (m_iss < 65535) m_iss++;
            if (e_last) m_drain = 1;
            else m_fill = 1;
            cur.delete();
        end
        if (hs_e) begin
            cur.push_back(e);
            if (cur.size() == K || e.l) begin
                e_val = '0; e_col = '0; e_ipv = '0;
                foreach (cur[j]) begin
                    e_val[(K-1-j)*VAL_W +: VAL_W] = cur[j].v;
                    e_col[(K-1-j)*COL_W +: COL_W] = cur[j].c;
                    e_ipv[K-1-j] = cur[j].i;
                end
                e_cnt = cur.size(); e_last = e.l; m_pend = 1; m_fill = 0;
            end
        end
        m_done = dn;
        if (dn) m_drain = 0;
        @(posedge clk); #1;
    endtask

    // rmode: 0 retire 4 cycles after issue, 1 random retire, 2 withhold retires until a credit stall.
    task automatic run_pass(input int n, input bit rnd, input int rmode, input bit hold);
        elem_t el[$];
        elem_t e;
        int idx = 0, cyc = 0, pc = 0, sc = 0;
        bit ev, gr, rv, hs_e, hs_g, stalled = 0, resume = 0;
        bit [3:0] rq = 0;
        for (int i = 0; i < n; i++) begin
            e.v = rnd ? VAL_W'($urandom) : VAL_W'(i + 1);
            e.c = rnd ? COL_W'($urandom) : COL_W'(10 + i);
            e.i = rnd ? 1'($urandom) : 1'(i % 3 == 2);
            e.l = i == n - 1;
            el.push_back(e);
        end
        step(1, 0, 0, 0, el[0]);
        while ((m_fill || m_pend || m_drain || m_done) && cyc < 3000) begin
            if (resume) begin
                chk("stall_resume", 64'(grp_valid), 64'(1));
                resume = 0;
            end
            pc = m_pend ? pc + 1 : 0;
            ev = idx < n && (!rnd || $urandom_range(0, 3) != 0);
            gr = hold ? pc > 3 : (!rnd || $urandom_range(0, 1) == 1);
            hs_e = ev && m_fill;
            hs_g = m_pend && m_o < MAXI && gr;
            if (rmode == 0) rv = rq[3];
            else if (rmode == 1 || stalled)
                rv = $urandom_range(0, 2) == 0 && (m_o > 0 || $urandom_range(0, 9) == 0);
            else begin
                rv = 0;
                if (m_pend && m_o == MAXI) begin
                    sc++;
                    if (sc == 3) chk("stall_grp_valid", 64'(grp_valid), 64'(0));
                    if (sc > 3) begin rv = 1; stalled = 1; resume = 1; end
                end
            end
            rq = {rq[2:0], hs_g};
            step(0, ev, gr, rv, idx < n ? el[idx] : el[n-1]);
            if (hs_e) idx++;
            cyc++;
        end
        if (cyc >= 3000) chk("pass_timeout", 64'(1), 64'(0));
    endtask

    initial begin
        vec_t tbl[4];
        elem_t z;
        z = '{v: 0, c: 0, i: 0, l: 0};
        tbl[0] = '{8, 2, 4, {8'd5, 8'd6, 8'd7, 8'd8}, {7'd14, 7'd15, 7'd16, 7'd17}, 4'b0100};
        tbl[1] = '{5, 2, 1, {8'd5, 24'd0}, {7'd14, 21'd0}, 4'b0000};
        tbl[2] = '{1, 1, 1, {8'd1, 24'd0}, {7'd10, 21'd0}, 4'b0000};
        tbl[3] = '{4, 1, 4, {8'd1, 8'd2, 8'd3, 8'd4}, {7'd10, 7'd11, 7'd12, 7'd13}, 4'b0010};
        model_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_elem_ready", 64'(elem_ready), 64'(0));
        chk("rst_grp_valid", 64'(grp_valid), 64'(0));
        chk("rst_payload", 64'({grp_val, grp_col, grp_ipv, grp_cnt, grp_last}), 64'(0));
        chk("rst_issued", 64'(issued_cnt), 64'(0));
        chk("rst_err_done", 64'({err, done}), 64'(0));

        foreach (tbl[t]) begin
            run_pass(tbl[t].n, 0, 0, 0);
            chk("tbl_groups", 64'(issued_cnt), 64'(tbl[t].groups));
            chk("tbl_last_cnt", 64'(seen_cnt), 64'(tbl[t].lcnt));
            chk("tbl_last_val", 64'(seen_val), 64'(tbl[t].lv));
            chk("tbl_last_col", 64'(seen_col), 64'(tbl[t].lc));
            chk("tbl_last_ipv", 64'(seen_ipv), 64'(tbl[t].li));
        end

        run_pass(22, 0, 2, 0);
        chk("stall_groups", 64'(issued_cnt), 64'(6));
        run_pass(9, 0, 0, 1);
        chk("hold_groups", 64'(issued_cnt), 64'(3));

        step(0, 0, 0, 1, z);
        chk("idle_err", 64'(err), 64'(1));
        step(0, 0, 0, 0, z);
        step(0, 0, 0, 0, z);

        repeat (30) run_pass($urandom_range(1, 20), 1, 1, 0);

        step(1, 0, 0, 0, z);
        step(0, 1, 0, 0, '{v: 8'h11, c: 7'd3, i: 1, l: 0});
        step(0, 1, 0, 0, '{v: 8'h22, c: 7'd4, i: 0, l: 0});
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_elem_ready", 64'(elem_ready), 64'(0));
        chk("midrst_payload", 64'({grp_val, grp_col, grp_ipv, grp_cnt}), 64'(0));
        run_pass(18, 0, 2, 0);
        chk("midrst_groups", 64'(issued_cnt), 64'(5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
